rcu_wdt_rstgen: RTL

// - Watchdog timer that produces the watchdog reset request consumed by the RCU (its wdt_rst_n_i).
// - Software programs and feeds it over APB4. If it is not fed before the count expires, it drives
//   an active-low reset pulse of fixed width into the RCU reset tree.
// - Sits in the always-on domain and is clocked by the RCU bypass clock.

---
 rtl/rcu_wdt_rstgen.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rcu_wdt_rstgen.sv
// Watchdog reset generator: APB4-programmed down-counter that drives a fixed-width active-low reset request.
// Defining RCU_WDT_IRQ_EN adds the WARN/ISTAT registers and the wdt_irq_o early-warning output.
module rcu_wdt_rstgen #(
    parameter int          CNT_WIDTH  = 32,
    parameter int          PSCR_WIDTH = 16,
    parameter int          RST_CYC    = 16,
    parameter logic [31:0] FEED_KEY   = 32'h5A5A_A5A5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] apb_paddr_i,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pready_o,
    output logic        apb_pslverr_o,
`ifdef RCU_WDT_IRQ_EN
    output logic        wdt_rst_n_o,
    output logic        wdt_irq_o
`else
    output logic        wdt_rst_n_o
`endif
);

    // state | meaning
    // IDLE  | counter held, waiting for EN 0->1
    // RUN   | counting down on prescaler ticks, FEED reloads
    // RST   | wdt_rst_n_o low for RST_CYC cycles, then reload
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RST  = 2'd2
    } state_t;

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0]        RST_LAST = RCW'(RST_CYC - 1);
    localparam logic [RCW-1:0]        RC_ONE   = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [PSCR_WIDTH-1:0] PS_ONE   = 1;

    state_t                state, state_nxt;
    logic                  ctrl_en, ctrl_lock;
    logic [PSCR_WIDTH-1:0] pscr, pscnt;
    logic [CNT_WIDTH-1:0]  load, cnt;
    logic [RCW-1:0]        rst_cnt;
    logic                  rst_n_nxt;

    logic       wr_en, rd_en, mapped, feed_key_ok;
    logic [3:0] idx;
    logic       ctrl_we, pscr_we, load_we;
    logic       en_rise, en_off, en_eff, feed_ok;
    logic       in_idle, in_run, in_rst;
    logic       tick, expire, pulse_done, reload, dec;
    logic [31:0] rdata;
    logic       err;
    logic       unused_addr;

    assign wr_en       = apb_psel_i & apb_penable_i & apb_pwrite_i;
    assign rd_en       = apb_psel_i & apb_penable_i & ~apb_pwrite_i;
    assign idx         = apb_paddr_i[5:2];
    assign unused_addr = ^{apb_paddr_i[31:6], apb_paddr_i[1:0]};
    assign feed_key_ok = (apb_pwdata_i == FEED_KEY);

`ifdef RCU_WDT_IRQ_EN
    assign mapped = (idx <= 4'd6);
`else
    assign mapped = (idx <= 4'd4);
`endif

    assign ctrl_we = wr_en & (idx == 4'd0) & ~ctrl_lock;
    assign pscr_we = wr_en & (idx == 4'd1) & ~ctrl_lock;
    assign load_we = wr_en & (idx == 4'd2) & ~ctrl_lock;
    assign feed_ok = wr_en & (idx == 4'd3) & feed_key_ok;

    assign en_rise = ctrl_we & apb_pwdata_i[0] & ~ctrl_en;
    assign en_off  = ctrl_we & ~apb_pwdata_i[0];
    // a CTRL write landing on the last pulse cycle decides where the pulse exits to
    assign en_eff  = ctrl_we ? apb_pwdata_i[0] : ctrl_en;

    assign in_idle    = (state == ST_IDLE);
    assign in_run     = (state == ST_RUN);
    assign in_rst     = (state == ST_RST);
    assign tick       = in_run & (pscnt == '0);
    assign expire     = tick & (cnt == '0);
    assign pulse_done = in_rst & (rst_cnt == '0);
    assign reload     = (in_idle & en_rise) | (in_run & ~en_off & feed_ok) | pulse_done;
    assign dec        = in_run & ~en_off & ~feed_ok & tick & (cnt != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_en   <= 1'b0;
            ctrl_lock <= 1'b0;
            pscr      <= '0;
            load      <= '0;
        end else begin
            if (ctrl_we) begin
                ctrl_en   <= apb_pwdata_i[0];
                ctrl_lock <= apb_pwdata_i[1];
            end
            if (pscr_we) pscr <= apb_pwdata_i[PSCR_WIDTH-1:0];
            if (load_we) load <= apb_pwdata_i[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en_rise) state_nxt = ST_RUN;
            ST_RUN: begin
                if (en_off)                   state_nxt = ST_IDLE;
                else if (expire && !feed_ok)  state_nxt = ST_RST;
            end
            ST_RST:  if (rst_cnt == '0) state_nxt = en_eff ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // reset request is a flop fed from next state so the pin never glitches
    always_comb begin
        rst_n_nxt = (state_nxt != ST_RST);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt         <= '0;
            pscnt       <= '0;
            rst_cnt     <= '0;
            wdt_rst_n_o <= 1'b1;
        end else begin
            wdt_rst_n_o <= rst_n_nxt;
            if (reload)   cnt <= load;
            else if (dec) cnt <= cnt - CNT_ONE;
            if (reload || tick) pscnt <= pscr;
            else if (in_run)    pscnt <= pscnt - PS_ONE;
            if (in_run && state_nxt == ST_RST)  rst_cnt <= RST_LAST;
            else if (in_rst && rst_cnt != '0)   rst_cnt <= rst_cnt - RC_ONE;
        end
    end

`ifdef RCU_WDT_IRQ_EN
    logic [CNT_WIDTH-1:0] warn;
    logic                 wf, wf_set, wf_clr;

    assign wf_set = dec & ((cnt - CNT_ONE) == warn);
    assign wf_clr = wr_en & (idx == 4'd6) & apb_pwdata_i[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            warn <= '0;
            wf   <= 1'b0;
        end else begin
            if (wr_en && idx == 4'd5 && !ctrl_lock) warn <= apb_pwdata_i[CNT_WIDTH-1:0];
            wf <= wf_set | (wf & ~wf_clr);
        end
    end

    assign wdt_irq_o = wf & ctrl_en;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            4'd0:    rdata = {30'd0, ctrl_lock, ctrl_en};
            4'd1:    rdata = 32'(pscr);
            4'd2:    rdata = 32'(load);
            4'd4:    rdata = 32'(cnt);
`ifdef RCU_WDT_IRQ_EN
            4'd5:    rdata = 32'(warn);
            4'd6:    rdata = {31'd0, wf};
`endif
            default: rdata = '0;
        endcase
    end

    always_comb begin
        err = 1'b0;
        if (rd_en) begin
            err = ~mapped;
        end else if (wr_en) begin
            case (idx)
                4'd0, 4'd1, 4'd2: err = ctrl_lock;
                4'd3:             err = ~feed_key_ok & ~in_idle;
`ifdef RCU_WDT_IRQ_EN
                4'd5:             err = ctrl_lock;
                4'd6:             err = 1'b0;
`endif
                default:          err = 1'b1;
            endcase
        end
    end

    assign apb_prdata_o  = rd_en ? rdata : 32'd0;
    assign apb_pslverr_o = err;
    assign apb_pready_o  = 1'b1;

endmodule
